// File: rtl/dcfeb_xfer_pkg.sv
// Shared definitions for the DCFEB sample transfer sequencer.
//   xfer_state_t : sequencer state encoding, also driven onto XSTATE for debug
//   DEF_*        : default event geometry and timing
//   clog2        : index width helper, never returns less than 1
package dcfeb_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_L1A   = 3'd2,
        ST_XFER  = 3'd3,
        ST_STALL = 3'd4
    } xfer_state_t;

    localparam int unsigned DEF_NCHIP    = 6;
    localparam int unsigned DEF_NCHAN    = 16;
    localparam int unsigned DEF_WAIT_CYC = 4;
    localparam int unsigned DEF_L1A_CYC  = 6;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/xfer_addr_ctr.sv
// Nested CHIP/CHAN word address counter. CHIP is the inner loop and wraps at
// NCHIP-1; CHAN steps when CHIP wraps and wraps at NCHAN-1.
//   CLK, RST   : clock, asynchronous active-high reset
//   clear      : return to word (0,0); overrides advance
//   advance    : step to the next word
//   chip, chan : registered address of the current word
//   first_nxt  : address being loaded this cycle is (0,0)
//   last_nxt   : address being loaded this cycle is (NCHAN-1,NCHIP-1)
//   last_cur   : current address is the final word of the event
module xfer_addr_ctr
    import dcfeb_xfer_pkg::*;
#(
    parameter int unsigned NCHIP = DEF_NCHIP,
    parameter int unsigned NCHAN = DEF_NCHAN,
    parameter int unsigned CPW   = clog2(NCHIP),
    parameter int unsigned CNW   = clog2(NCHAN)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           clear,
    input  logic           advance,
    output logic [CPW-1:0] chip,
    output logic [CNW-1:0] chan,
    output logic           first_nxt,
    output logic           last_nxt,
    output logic           last_cur
);

    localparam logic [CPW-1:0] CHIP_MAX = CPW'(NCHIP - 1);
    localparam logic [CNW-1:0] CHAN_MAX = CNW'(NCHAN - 1);

    logic [CPW-1:0] chip_n;
    logic [CNW-1:0] chan_n;

    always_comb begin
        chip_n = chip;
        chan_n = chan;
        if (clear) begin
            chip_n = '0;
            chan_n = '0;
        end else if (advance) begin
            if (chip == CHIP_MAX) begin
                chip_n = '0;
                chan_n = (chan == CHAN_MAX) ? '0 : chan + CNW'(1);
            end else begin
                chip_n = chip + CPW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chip <= '0;
            chan <= '0;
        end else begin
            chip <= chip_n;
            chan <= chan_n;
        end
    end

    assign first_nxt = (chip_n == '0) && (chan_n == '0);
    assign last_nxt  = (chip_n == CHIP_MAX) && (chan_n == CHAN_MAX);
    assign last_cur  = (chip == CHIP_MAX) && (chan == CHAN_MAX);

endmodule

// File: rtl/sample_xfer_seq.sv
// Per-L1A sequencer moving one event of buffered ADC samples into the readout
// path: WAIT for WAIT_CYC cycles, strobe the L1A/header FIFO for L1A_CYC
// cycles, then stream NCHIP*NCHAN sample words, pausing while HOLD is high.
//   CLK, RST  : clock, asynchronous active-high reset
//   RDY       : event samples ready (level)
//   JTAG_MODE : JTAG owns the FIFOs; blocks new event starts only
//   HOLD      : downstream full; freezes the word stream
//   L1A_RD_EN : L1A/header FIFO read strobe
//   RDENA     : sample read enable, one word per high cycle
//   CHIP/CHAN : address of the current word
//   FIRST     : with RDENA on word (0,0)
//   LAST      : with RDENA on the final word
//   DONE      : one-cycle pulse after the final word
//   BUSY      : sequencer not idle
//   XSTATE    : state encoding for debug
module sample_xfer_seq
    import dcfeb_xfer_pkg::*;
#(
    parameter int unsigned NCHIP    = DEF_NCHIP,
    parameter int unsigned NCHAN    = DEF_NCHAN,
    parameter int unsigned WAIT_CYC = DEF_WAIT_CYC,
    parameter int unsigned L1A_CYC  = DEF_L1A_CYC,
    parameter int unsigned CPW      = clog2(NCHIP),
    parameter int unsigned CNW      = clog2(NCHAN)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           RDY,
    input  logic           JTAG_MODE,
    input  logic           HOLD,
    output logic           L1A_RD_EN,
    output logic           RDENA,
    output logic [CPW-1:0] CHIP,
    output logic [CNW-1:0] CHAN,
    output logic           FIRST,
    output logic           LAST,
    output logic           DONE,
    output logic           BUSY,
    output logic [2:0]     XSTATE
);

    localparam int unsigned CNT_MAX = (WAIT_CYC > L1A_CYC) ? WAIT_CYC : L1A_CYC;
    localparam int unsigned CW      = clog2(CNT_MAX);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] L1A_LAST  = CW'(L1A_CYC - 1);

    xfer_state_t   state;
    xfer_state_t   nextstate;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          start_ok;
    logic          addr_clear;
    logic          addr_adv;
    logic          first_nxt;
    logic          last_nxt;
    logic          last_cur;

    assign start_ok = RDY & ~JTAG_MODE;

    always_comb begin
        nextstate = ST_IDLE;
        cnt_nxt   = '0;
        case (state)
            ST_IDLE: begin
                nextstate = start_ok ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    nextstate = ST_L1A;
                end else begin
                    nextstate = ST_WAIT;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            ST_L1A: begin
                if (cnt == L1A_LAST) begin
                    nextstate = ST_XFER;
                end else begin
                    nextstate = ST_L1A;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            ST_XFER: begin
                // The final word always completes, even with HOLD high;
                // a pending start chains straight into the next WAIT.
                if (last_cur) begin
                    nextstate = start_ok ? ST_WAIT : ST_IDLE;
                end else if (HOLD) begin
                    nextstate = ST_STALL;
                end else begin
                    nextstate = ST_XFER;
                end
            end
            ST_STALL: begin
                nextstate = HOLD ? ST_STALL : ST_XFER;
            end
            default: begin
                nextstate = ST_IDLE;
            end
        endcase
    end

    // Every XFER cycle consumes a word, so the address moves on even when
    // HOLD sends us to STALL; STALL then shows the next un-read word.
    assign addr_adv   = (state == ST_XFER);
    assign addr_clear = (nextstate != ST_XFER) && (nextstate != ST_STALL);

    xfer_addr_ctr #(
        .NCHIP (NCHIP),
        .NCHAN (NCHAN),
        .CPW   (CPW),
        .CNW   (CNW)
    ) u_addr (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (addr_clear),
        .advance   (addr_adv),
        .chip      (CHIP),
        .chan      (CHAN),
        .first_nxt (first_nxt),
        .last_nxt  (last_nxt),
        .last_cur  (last_cur)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            L1A_RD_EN <= 1'b0;
            RDENA     <= 1'b0;
            FIRST     <= 1'b0;
            LAST      <= 1'b0;
            DONE      <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state     <= nextstate;
            cnt       <= cnt_nxt;
            L1A_RD_EN <= (nextstate == ST_L1A);
            RDENA     <= (nextstate == ST_XFER);
            FIRST     <= (nextstate == ST_XFER) && first_nxt;
            LAST      <= (nextstate == ST_XFER) && last_nxt;
            DONE      <= (state == ST_XFER) && last_cur;
            BUSY      <= (nextstate != ST_IDLE);
        end
    end

    assign XSTATE = state;

endmodule

// File: tb/tb_sample_xfer_seq.sv
// Bench for sample_xfer_seq: a default-geometry instance and a small
// (3 chips x 5 channels, WAIT 1, L1A 2) instance share the same inputs and are
// compared every cycle against an event-timeline model.
module tb_sample_xfer_seq;

    logic CLK = 1'b0;
    logic RST;
    logic RDY;
    logic JTAG_MODE;
    logic HOLD;

    logic       l1a0, rdena0, first0, last0, done0, busy0;
    logic [2:0] chip0;
    logic [3:0] chan0;
    logic [2:0] xs0;
    logic       l1a1, rdena1, first1, last1, done1, busy1;
    logic [1:0] chip1;
    logic [2:0] chan1;
    logic [2:0] xs1;

    always #5 CLK = ~CLK;

    sample_xfer_seq u_dut0 (
        .CLK(CLK), .RST(RST), .RDY(RDY), .JTAG_MODE(JTAG_MODE), .HOLD(HOLD),
        .L1A_RD_EN(l1a0), .RDENA(rdena0), .CHIP(chip0), .CHAN(chan0),
        .FIRST(first0), .LAST(last0), .DONE(done0), .BUSY(busy0), .XSTATE(xs0)
    );

    sample_xfer_seq #(
        .NCHIP(3), .NCHAN(5), .WAIT_CYC(1), .L1A_CYC(2)
    ) u_dut1 (
        .CLK(CLK), .RST(RST), .RDY(RDY), .JTAG_MODE(JTAG_MODE), .HOLD(HOLD),
        .L1A_RD_EN(l1a1), .RDENA(rdena1), .CHIP(chip1), .CHAN(chan1),
        .FIRST(first1), .LAST(last1), .DONE(done1), .BUSY(busy1), .XSTATE(xs1)
    );

    // Output bundle: [24]L1A [23]RDENA [22]FIRST [21]LAST [20]DONE [19]BUSY
    // [18:16]XSTATE [15:8]CHIP [7:0]CHAN
    logic [24:0] got0, got1;
    assign got0 = {l1a0, rdena0, first0, last0, done0, busy0, xs0, 8'(chip0), 8'(chan0)};
    assign got1 = {l1a1, rdena1, first1, last1, done1, busy1, xs1, 8'(chip1), 8'(chan1)};

    function automatic int p_nc(input int i); return (i == 0) ? 6 : 3;  endfunction
    function automatic int p_nh(input int i); return (i == 0) ? 16 : 5; endfunction
    function automatic int p_wc(input int i); return (i == 0) ? 4 : 1;  endfunction
    function automatic int p_lc(input int i); return (i == 0) ? 6 : 2;  endfunction

    // Model state: el = cycles since the event started (1..W wait,
    // W+1..W+L header read, beyond that transfer), w = words already read.
    typedef struct {
        int busy;
        int el;
        int w;
        int st;
        int done;
    } mst_t;

    mst_t m[2];

    function automatic mst_t m_zero();
        mst_t z;
        z.busy = 0; z.el = 0; z.w = 0; z.st = 0; z.done = 0;
        return z;
    endfunction

    function automatic mst_t m_next(input mst_t c, input int i, input logic rdy,
                                    input logic jtag, input logic hold);
        mst_t n;
        int nw;
        int pre;
        n   = c;
        nw  = p_nc(i) * p_nh(i);
        pre = p_wc(i) + p_lc(i);
        n.done = 0;
        if (c.busy == 0) begin
            if (rdy && !jtag) begin
                n.busy = 1; n.el = 1; n.w = 0; n.st = 0;
            end
        end else if (c.el <= pre) begin
            n.el = c.el + 1;
        end else if (c.st != 0) begin
            if (!hold) n.st = 0;
        end else begin
            n.w = c.w + 1;
            if (n.w == nw) begin
                n.done = 1;
                n.w    = 0;
                if (rdy && !jtag) n.el = 1;
                else              n.busy = 0;
            end else if (hold) begin
                n.st = 1;
            end
        end
        return n;
    endfunction

    function automatic logic [24:0] m_out(input mst_t c, input int i);
        int xs;
        int nw;
        logic rd;
        nw = p_nc(i) * p_nh(i);
        if (c.busy == 0)                    xs = 0;
        else if (c.el <= p_wc(i))           xs = 1;
        else if (c.el <= p_wc(i) + p_lc(i)) xs = 2;
        else if (c.st != 0)                 xs = 4;
        else                                xs = 3;
        rd = (xs == 3);
        return {xs == 2, rd, rd && (c.w == 0), rd && (c.w == nw - 1),
                c.done != 0, c.busy != 0, 3'(xs),
                8'(c.w % p_nc(i)), 8'(c.w / p_nc(i))};
    endfunction

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) m[i] <= m_zero();
            else     m[i] <= m_next(m[i], i, RDY, JTAG_MODE, HOLD);
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int wcount[2], max_chip[2], last_chip[2], last_chan[2];
    int l1a_first[2], l1a_last[2], ndone[2], prev_done[2], last_done[2];
    int xs_done[2], nstall[2], nbusy[2];

    logic [24:0] gv, ev;

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            gv = (i == 0) ? got0 : got1;
            ev = m_out(m[i], i);
            checks++;
            if (gv !== ev) begin
                failures++;
                $display("FAIL outputs dut%0d cyc=%0d got=%h exp=%h", i, cyc, gv, ev);
            end
            if (gv[23]) begin
                wcount[i]++;
                last_chip[i] = int'(gv[15:8]);
                last_chan[i] = int'(gv[7:0]);
                if (int'(gv[15:8]) > max_chip[i]) max_chip[i] = int'(gv[15:8]);
            end
            if (gv[24]) begin
                if (l1a_first[i] < 0) l1a_first[i] = cyc;
                l1a_last[i] = cyc;
            end
            if (gv[20]) begin
                ndone[i]++;
                prev_done[i] = last_done[i];
                last_done[i] = cyc;
                xs_done[i]   = int'(gv[18:16]);
            end
            if (gv[18:16] == 3'd4) nstall[i]++;
            if (gv[19]) nbusy[i]++;
        end
    end

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            wcount[i] = 0; max_chip[i] = 0; last_chip[i] = -1; last_chan[i] = -1;
            l1a_first[i] = -1; l1a_last[i] = -1; ndone[i] = 0;
            prev_done[i] = -1; last_done[i] = -1; xs_done[i] = -1;
            nstall[i] = 0; nbusy[i] = 0;
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_event(output int s);
        RDY = 1'b1;
        s   = cyc;
        tick(1);
        RDY = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target, input int maxc);
        int n;
        n = 0;
        while (ndone[i] < target && n < maxc) begin
            tick(1);
            n++;
        end
        check($sformatf("wait_done_dut%0d", i), ndone[i], target);
    endtask

    int s;

    initial begin
        clear_stats();
        RST = 1'b1; RDY = 1'b0; JTAG_MODE = 1'b0; HOLD = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_out0", int'(got0), 0);
        check("reset_out1", int'(got1), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        tick(3);

        // single event, no backpressure
        clear_stats();
        start_event(s);
        wait_done(0, 1, 200);
        tick(3);
        check("s1_l1a_first0", l1a_first[0], s + 5);
        check("s1_l1a_last0", l1a_last[0], s + 10);
        check("s1_words0", wcount[0], 96);
        check("s1_last_chan0", last_chan[0], 15);
        check("s1_last_chip0", last_chip[0], 5);
        check("s1_done0", last_done[0], s + 107);
        check("s1_busy_cycles0", nbusy[0], 106);
        check("s1_l1a_first1", l1a_first[1], s + 2);
        check("s1_words1", wcount[1], 15);
        check("s1_max_chip1", max_chip[1], 2);
        check("s1_last_chan1", last_chan[1], 4);
        check("s1_last_chip1", last_chip[1], 2);
        check("s1_done1", last_done[1], s + 19);

        // JTAG blocks starts, but not an event already running
        clear_stats();
        JTAG_MODE = 1'b1; RDY = 1'b1;
        tick(10);
        check("s2_jtag_idle0", nbusy[0], 0);
        check("s2_jtag_idle1", nbusy[1], 0);
        RDY = 1'b0; JTAG_MODE = 1'b0;
        tick(1);
        start_event(s);
        tick(30);
        JTAG_MODE = 1'b1;
        wait_done(0, 1, 200);
        JTAG_MODE = 1'b0;
        tick(2);
        check("s2_words0", wcount[0], 96);

        // HOLD for 3 cycles starting at word 40
        clear_stats();
        start_event(s);
        tick(50);
        HOLD = 1'b1;
        tick(3);
        HOLD = 1'b0;
        wait_done(0, 1, 200);
        tick(2);
        check("s3_words0", wcount[0], 96);
        check("s3_stall0", nstall[0], 3);
        check("s3_done0", last_done[0], s + 110);

        // RDY held high: back-to-back events
        clear_stats();
        RDY = 1'b1;
        s   = cyc;
        wait_done(0, 2, 400);
        RDY = 1'b0;
        check("s4_done_a0", prev_done[0], s + 107);
        check("s4_done_gap0", last_done[0] - prev_done[0], 106);
        check("s4_state_at_done0", xs_done[0], 1);
        wait_done(0, 3, 200);
        tick(30);

        // reset mid-transfer at word 50
        clear_stats();
        start_event(s);
        tick(60);
        @(negedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        check("s5_rst_out0", int'(got0), 0);
        check("s5_words_before0", wcount[0], 51);
        check("s5_word50_chip0", last_chip[0], 2);
        check("s5_word50_chan0", last_chan[0], 8);
        @(posedge CLK);
        #1 RST = 1'b0;
        tick(3);
        check("s5_no_done0", ndone[0], 0);
        start_event(s);
        wait_done(0, 1, 200);
        tick(2);
        check("s5_words_after0", wcount[0], 147);
        check("s5_done0", last_done[0], s + 107);

        // randomized traffic
        repeat (800) begin
            RDY       = ($urandom % 4) == 0;
            JTAG_MODE = ($urandom % 8) == 0;
            HOLD      = ($urandom % 4) == 0;
            RST       = ($urandom % 250) == 0;
            tick(1);
        end
        RST = 1'b0; RDY = 1'b0; JTAG_MODE = 1'b0; HOLD = 1'b0;
        tick(250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
